// File: rtl/host_pkg.sv
// Shared constants and types for the host board: memory/IO map and UART state encoding.
package host_pkg;

    localparam logic [7:0]  UART_PORT = 8'h08;
    localparam int unsigned RAM_AW    = 14;
    localparam logic [15:0] RAM_TOP   = 16'h3FFF;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

    // Clock cycles per UART bit, rounded to nearest.
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 transmit-only UART; accepts a byte on load only while idle, LSB first.
module uart_tx_core
    import host_pkg::*;
#(
    parameter int unsigned DIV = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       load,
    output logic       busy,
    output logic       tx
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    uart_state_t   state, state_nx;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          tick;

    assign tick = (baud_cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= UART_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            UART_IDLE:  if (load) state_nx = UART_START;
            UART_START: if (tick) state_nx = UART_DATA;
            UART_DATA:  if (tick && bit_cnt == 3'd7) state_nx = UART_STOP;
            UART_STOP:  if (tick) state_nx = UART_IDLE;
            default:    state_nx = UART_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            if (state == UART_IDLE || tick) baud_cnt <= '0;
            else                            baud_cnt <= baud_cnt + 1'b1;

            if (state == UART_IDLE && load)      shreg <= data;
            else if (state == UART_DATA && tick) shreg <= {1'b0, shreg[7:1]};

            if (state != UART_DATA) bit_cnt <= '0;
            else if (tick)          bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // tx decodes straight from state so an async reset returns the line high at once.
    always_comb begin
        tx   = 1'b1;
        busy = 1'b1;
        case (state)
            UART_IDLE:  busy = 1'b0;
            UART_START: tx   = 1'b0;
            UART_DATA:  tx   = shreg[0];
            default:    ;
        endcase
    end

endmodule

// File: rtl/z80_top_direct_n.sv
// Compact Z80-compatible core: the instruction subset the board firmware uses,
// with Z80-style M1/MREQ/IORQ/RD/WR bus cycles (T1 address, T2-T3 strobes).
module z80_top_direct_n (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        nWAIT,
    input  logic        nINT,
    input  logic        nNMI,
    input  logic        nBUSRQ,
    output logic        nM1,
    output logic        nMREQ,
    output logic        nIORQ,
    output logic        nRD,
    output logic        nWR,
    output logic [15:0] A,
    inout  wire  [7:0]  D
);

    typedef enum logic [2:0] {S_OP, S_N1, S_N2, S_MRD, S_MWR, S_IRD, S_IWR, S_HALT} cyc_t;

    cyc_t        st, st_nx;
    logic        fpga_reset;
    logic        core_rst;
    logic [1:0]  t;
    logic        done;
    logic [15:0] pc, jr_tgt;
    logic [7:0]  a, b, ir, n1, n2;
    logic        zf;
    logic        unused_inputs;

    assign fpga_reset    = 1'b0;
    assign core_rst      = fpga_reset || !nRESET;
    assign done          = (t == 2'd2);
    assign jr_tgt        = pc + 16'd1 + {{8{D[7]}}, D};
    assign unused_inputs = &{nINT, nNMI, nBUSRQ};

    always_ff @(posedge CLK or posedge core_rst) begin
        if (core_rst) begin
            st <= S_OP;
            t  <= '0;
        end else begin
            st <= st_nx;
            if (st == S_HALT || done)  t <= '0;
            else if (t != 2'd1 || nWAIT) t <= t + 2'd1;
        end
    end

    always_comb begin
        st_nx = st;
        if (done) begin
            st_nx = S_OP;
            case (st)
                S_OP: case (D)
                    8'h3E, 8'hE6, 8'hD3, 8'hDB, 8'h18, 8'h20, 8'h28,
                    8'h32, 8'h3A, 8'hC3: st_nx = S_N1;
                    8'h76:               st_nx = S_HALT;
                    default:             ;
                endcase
                S_N1: case (ir)
                    8'hD3:               st_nx = S_IWR;
                    8'hDB:               st_nx = S_IRD;
                    8'h32, 8'h3A, 8'hC3: st_nx = S_N2;
                    default:             ;
                endcase
                S_N2: case (ir)
                    8'h32:   st_nx = S_MWR;
                    8'h3A:   st_nx = S_MRD;
                    default: ;
                endcase
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge core_rst) begin
        if (core_rst) begin
            pc <= '0;
            a  <= '1;
            b  <= '0;
            ir <= '0;
            n1 <= '0;
            n2 <= '0;
            zf <= 1'b0;
        end else if (done) begin
            case (st)
                S_OP: begin
                    ir <= D;
                    pc <= pc + 16'd1;
                    if (D == 8'h47) b <= a;
                    if (D == 8'h78) a <= b;
                end
                S_N1: begin
                    n1 <= D;
                    pc <= pc + 16'd1;
                    case (ir)
                        8'h3E: a <= D;
                        8'hE6: begin
                            a  <= a & D;
                            zf <= (a & D) == 8'h00;
                        end
                        8'h18: pc <= jr_tgt;
                        8'h20: if (!zf) pc <= jr_tgt;
                        8'h28: if (zf)  pc <= jr_tgt;
                        default: ;
                    endcase
                end
                S_N2: begin
                    n2 <= D;
                    pc <= (ir == 8'hC3) ? {D, n1} : pc + 16'd1;
                end
                S_MRD, S_IRD: a <= D;
                default: ;
            endcase
        end
    end

    always_comb begin
        A     = pc;
        nM1   = 1'b1;
        nMREQ = 1'b1;
        nIORQ = 1'b1;
        nRD   = 1'b1;
        nWR   = 1'b1;
        case (st)
            S_OP: begin
                nM1   = 1'b0;
                nMREQ = (t == 2'd0);
                nRD   = (t == 2'd0);
            end
            S_N1, S_N2: begin
                nMREQ = (t == 2'd0);
                nRD   = (t == 2'd0);
            end
            S_MRD: begin
                A     = {n2, n1};
                nMREQ = (t == 2'd0);
                nRD   = (t == 2'd0);
            end
            S_MWR: begin
                A     = {n2, n1};
                nMREQ = (t == 2'd0);
                nWR   = (t == 2'd0);
            end
            S_IRD: begin
                A     = {a, n1};
                nIORQ = (t == 2'd0);
                nRD   = (t == 2'd0);
            end
            S_IWR: begin
                A     = {a, n1};
                nIORQ = (t == 2'd0);
                nWR   = (t == 2'd0);
            end
            default: ;
        endcase
    end

    assign D = (st == S_MWR || st == S_IWR) ? a : 'z;

endmodule

// File: rtl/host.sv
// FPGA top: Z80 core, 16 KB RAM at 0x0000, UART transmitter on I/O port 0x08.
module host
  import host_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned BAUD     = 115_200,
  parameter string       RAM_FILE = "ram.hex"
) (
  input  logic clk,
  input  logic reset,
  output logic uart_tx
);

  logic [15:0] cpu_a;
  tri   [7:0]  cpu_d;
  logic        n_m1, n_mreq, n_iorq, n_rd, n_wr;
  logic        mem_rd, io_rd, mem_wr_act, io_wr_act, mem_wr_q, io_wr_q;
  logic        in_ram, mem_we, uart_load, uart_busy;
  logic [7:0]  rd_data;
  logic [7:0]  ram [0:(1 << RAM_AW) - 1];

  z80_top_direct_n z80_ (
    .CLK    (clk),
    .nRESET (reset),
    .nWAIT  (1'b1),
    .nINT   (1'b1),
    .nNMI   (1'b1),
    .nBUSRQ (1'b1),
    .nM1    (n_m1),
    .nMREQ  (n_mreq),
    .nIORQ  (n_iorq),
    .nRD    (n_rd),
    .nWR    (n_wr),
    .A      (cpu_a),
    .D      (cpu_d)
  );

  assign in_ram     = (cpu_a <= RAM_TOP);
  assign mem_rd     = !n_mreq && !n_rd;
  assign io_rd      = !n_iorq && !n_rd && n_m1;
  assign mem_wr_act = !n_mreq && !n_wr;
  assign io_wr_act  = !n_iorq && !n_wr && n_m1;

  always_comb begin
    rd_data = 8'hFF;
    if (mem_rd) begin
      if (in_ram) rd_data = ram[cpu_a[RAM_AW-1:0]];
    end else if (io_rd && cpu_a[7:0] == UART_PORT) begin
      rd_data = {7'b0, uart_busy};
    end
  end

  // Interrupt acknowledge (M1 with IORQ) is excluded by io_rd, leaving the bus floating.
  assign cpu_d = (mem_rd || io_rd) ? rd_data : 'z;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_wr_q <= 1'b0;
      io_wr_q  <= 1'b0;
    end else begin
      mem_wr_q <= mem_wr_act;
      io_wr_q  <= io_wr_act;
    end
  end

  assign mem_we    = mem_wr_act && !mem_wr_q && in_ram;
  assign uart_load = io_wr_act && !io_wr_q && cpu_a[7:0] == UART_PORT;

  always_ff @(posedge clk) begin
    if (mem_we) ram[cpu_a[RAM_AW-1:0]] <= cpu_d;
  end

  uart_tx_core #(
    .DIV (baud_div(CLK_HZ, BAUD))
  ) uart_ (
    .clk   (clk),
    .reset (reset),
    .data  (cpu_d),
    .load  (uart_load),
    .busy  (uart_busy),
    .tx    (uart_tx)
  );

endmodule

// File: tb/tb_host.sv
// Board-level bench: firmware images loaded into RAM, UART frames decoded and scoreboarded.
module tb_host;

    localparam int DIV   = 434;
    localparam int FRAME = 10 * DIV;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic uart_tx;

    host #(.RAM_FILE("")) dut (
        .clk     (clk),
        .reset   (reset),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q [$];
    logic [7:0] fw [$];
    int         checks   = 0;
    int         failures = 0;
    bit         in_frame = 1'b0;
    bit         smp [FRAME];
    logic [7:0] mem_model [int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference view of the memory map: RAM below 0x4000, 0xFF elsewhere.
    function automatic void model_wr(input int addr, input logic [7:0] v);
        if (addr < 16384) mem_model[addr] = v;
    endfunction
    function automatic logic [7:0] model_rd(input int addr);
        if (addr < 16384 && mem_model.exists(addr)) return mem_model[addr];
        return 8'hFF;
    endfunction

    // Monitor: capture each frame clock by clock, decode, compare with scoreboard.
    initial begin : monitor
        bit prev;
        bit aborted;
        bit mid;
        logic [7:0] got, e;
        int glitch;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (reset && prev && !uart_tx) begin
                in_frame = 1'b1;
                aborted  = 1'b0;
                for (int i = 0; i < FRAME; i++) begin
                    if (i != 0) @(negedge clk);
                    if (!reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    smp[i] = uart_tx;
                end
                if (!aborted) begin
                    got    = '0;
                    glitch = 0;
                    for (int k = 0; k < 10; k++) begin
                        mid = smp[k * DIV + DIV / 2];
                        for (int j = 0; j < DIV; j++)
                            if (smp[k * DIV + j] != mid) glitch++;
                        if (k >= 1 && k <= 8) got[k-1] = mid;
                    end
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL frame_unexpected: got byte 0x%02h, expected no frame", got);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_byte", 32'(got), 32'(e));
                        check("frame_shape", {29'd0, smp[DIV/2], smp[9*DIV + DIV/2], glitch == 0}, 32'b011);
                    end
                end
                in_frame = 1'b0;
            end
            prev = uart_tx;
        end
    end

    task automatic emit(input logic [7:0] v);
        fw.push_back(v);
    endtask
    task automatic fw_poll();
        emit(8'hDB); emit(8'h08); emit(8'hE6); emit(8'h01); emit(8'h20); emit(8'hFA);
    endtask
    task automatic fw_out(input logic [7:0] c);
        emit(8'h3E); emit(c); emit(8'hD3); emit(8'h08);
    endtask

    task automatic boot();
        reset = 1'b0;
        repeat (4) @(posedge clk);
        for (int i = 0; i < fw.size(); i++) dut.ram[14'(i)] = fw[i];
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || in_frame) && c < 6 * FRAME) begin
            @(posedge clk);
            c++;
        end
        check({"drain_", name}, 32'(exp_q.size()), 32'd0);
        repeat (2 * DIV) @(posedge clk);
        c = 0;
        while (in_frame && c < 2 * FRAME) begin
            @(posedge clk);
            c++;
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : stim
        int bad;
        int c;
        logic [7:0] x, y;

        // Reset hold with power-on reset pulsed.
        bad = 0;
        force dut.z80_.fpga_reset = 1'b1;
        repeat (20) begin @(negedge clk); if (uart_tx !== 1'b1) bad++; end
        force dut.z80_.fpga_reset = 1'b0;
        repeat (20) begin @(negedge clk); if (uart_tx !== 1'b1) bad++; end
        release dut.z80_.fpga_reset;
        check("reset_tx_idle", 32'(bad), 32'd0);
        check("reset_busy", 32'(dut.uart_.busy), 32'd0);

        fw.delete(); emit(8'h76);
        boot();
        bad = 0;
        repeat (2 * DIV) begin @(negedge clk); if (uart_tx !== 1'b1) bad++; end
        check("idle_after_boot", 32'(bad), 32'd0);

        // Single character.
        fw.delete(); fw_out(8'h41); emit(8'h76);
        exp_q.push_back(8'h41);
        boot();
        drain("single");

        // "Hi" with polling; status captured right after each OUT.
        fw.delete();
        fw_poll(); fw_out(8'h48); emit(8'hDB); emit(8'h08); emit(8'h32); emit(8'h00); emit(8'h30);
        fw_poll(); fw_out(8'h69); emit(8'hDB); emit(8'h08); emit(8'h32); emit(8'h01); emit(8'h30);
        emit(8'h76);
        dut.ram[14'h3000] = 8'h00;
        dut.ram[14'h3001] = 8'h00;
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h69);
        boot();
        drain("hi");
        check("status_busy_0", 32'(dut.ram[14'h3000]), 32'd1);
        check("status_busy_1", 32'(dut.ram[14'h3001]), 32'd1);

        // Write while busy: second byte dropped.
        x = 8'($urandom_range(0, 255));
        y = 8'($urandom_range(0, 255));
        fw.delete(); fw_out(x); fw_out(y); emit(8'h76);
        exp_q.push_back(x);
        boot();
        drain("busy_drop");

        // Random string with polling.
        fw.delete();
        for (int i = 0; i < 3; i++) begin
            x = 8'($urandom_range(0, 255));
            fw_poll(); fw_out(x);
            exp_q.push_back(x);
        end
        emit(8'h76);
        boot();
        drain("random_str");

        // RAM top and unmapped space echoed over the UART.
        mem_model.delete();
        model_wr(16'h3FFF, 8'h5A);
        model_wr(16'h4000, 8'h5A);
        fw.delete();
        emit(8'h3E); emit(8'h5A); emit(8'h32); emit(8'hFF); emit(8'h3F);
        emit(8'h3E); emit(8'h00);
        emit(8'h32); emit(8'h00); emit(8'h40);
        emit(8'h3A); emit(8'hFF); emit(8'h3F); emit(8'hD3); emit(8'h08);
        fw_poll();
        emit(8'h3A); emit(8'h00); emit(8'h40); emit(8'hD3); emit(8'h08);
        emit(8'h76);
        exp_q.push_back(model_rd(16'h3FFF));
        exp_q.push_back(model_rd(16'h4000));
        boot();
        drain("ram_map");

        // Reset mid-frame during data bit 3 (held low), then full frame after restart.
        x = 8'($urandom_range(0, 255)) & 8'hF7;
        fw.delete(); fw_out(x); emit(8'h76);
        exp_q.push_back(x);
        boot();
        c = 0;
        while (uart_tx && c < 500) begin @(posedge clk); c++; end
        check("midframe_start_seen", 32'(uart_tx), 32'd0);
        repeat (4 * DIV + DIV / 2) @(posedge clk);
        @(negedge clk);
        check("midframe_bit3_low", 32'(uart_tx), 32'd0);
        reset = 1'b0;
        #1;
        check("abort_tx_high", 32'(uart_tx), 32'd1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        drain("after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
